tk1_spi_slave: RTL and testbench

TK1_SPI_SLAVE -- requirements
Module: tk1_spi_slave

---
 rtl/tk1_spi_slave.sv | 204 ++++++++++++++++++++
 tb/tb_tk1_spi_slave.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tk1_spi_slave.sv
// Purpose : SPI mode-0 slave, one byte in/out per 8 SCK cycles, with a single TX holding register.
// Latency : SCK/SS/MOSI see 2 clk of synchronisation plus 1 clk to act; rx_data/rx_avail update 1 clk after the rise event.
// Backpr. : tx_ready low while the holding register is full (writes then dropped); rx bytes never stall, rx_overrun flags loss.
//
// Ports:
//   clk, reset_n            system clock, async active-low reset
//   spi_ss, spi_sck         SPI select (active-low) and clock, asynchronous to clk
//   spi_mosi, spi_miso      serial data in/out, MSB first
//   tx_data, tx_data_vld    response byte write into the holding register
//   tx_ready                holding register empty
//   rx_data, rx_avail       last received byte and its "unread" flag
//   rx_ack                  clears rx_avail and rx_overrun
//   rx_overrun              sticky: a byte landed while the previous one was unread
//   spi_active              synchronised, inverted spi_ss

module tk1_spi_slave #(
   parameter logic [7:0] IDLE_FILL = 8'hff
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       spi_ss,
   input  logic       spi_sck,
   input  logic       spi_mosi,
   output logic       spi_miso,
   input  logic [7:0] tx_data,
   input  logic       tx_data_vld,
   output logic       tx_ready,
   output logic [7:0] rx_data,
   output logic       rx_avail,
   input  logic       rx_ack,
   output logic       rx_overrun,
   output logic       spi_active
);

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   // ------------------------------------------------------------------
   // Input synchronisers. ss resets high so reset release never looks
   // like a frame start; sck_prev resets to the sck reset value so no
   // edge is seen either.
   // ------------------------------------------------------------------
   logic [1:0] ss_ff;
   logic [1:0] sck_ff;
   logic [1:0] mosi_ff;
   logic       sck_prev;
   logic       ss_s;
   logic       sck_s;
   logic       mosi_s;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         ss_ff    <= 2'b11;
         sck_ff   <= 2'b00;
         mosi_ff  <= 2'b00;
         sck_prev <= 1'b0;
      end else begin
         ss_ff    <= {ss_ff[0], spi_ss};
         sck_ff   <= {sck_ff[0], spi_sck};
         mosi_ff  <= {mosi_ff[0], spi_mosi};
         sck_prev <= sck_ff[1];
      end
   end

   assign ss_s   = ss_ff[1];
   assign sck_s  = sck_ff[1];
   assign mosi_s = mosi_ff[1];

   logic rise_evt;
   logic fall_evt;

   assign rise_evt = sck_s & ~sck_prev & ~ss_s;
   assign fall_evt = ~sck_s & sck_prev & ~ss_s;

   // ------------------------------------------------------------------
   // Frame control FSM
   // ------------------------------------------------------------------
   state_t state;
   state_t state_nxt;
   logic   frame_start;
   logic   frame_end;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      frame_start = 1'b0;
      frame_end   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (!ss_s) begin
               state_nxt   = ST_ACTIVE;
               frame_start = 1'b1;
            end
         end
         ST_ACTIVE: begin
            if (ss_s) begin
               state_nxt = ST_IDLE;
               frame_end = 1'b1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath control. Frame start owns the shift registers for its
   // cycle, so any edge coinciding with it is dropped.
   // ------------------------------------------------------------------
   logic [2:0] bit_cnt;
   logic [7:0] rx_shift;
   logic [7:0] tx_shift;
   logic [7:0] hold_dat;
   logic       hold_full;
   logic [7:0] rx_byte;
   logic [7:0] next_tx_byte;
   logic       byte_done;
   logic       tx_load;
   logic       tx_shift_en;

   assign rx_byte      = {rx_shift[6:0], mosi_s};
   assign next_tx_byte = hold_full ? hold_dat : IDLE_FILL;
   assign byte_done    = rise_evt & ~frame_start & (bit_cnt == 3'd7);
   // Reloading on the fall after bit 8 puts the next response MSB on the
   // wire before the master's next rising edge.
   assign tx_load      = frame_start | (fall_evt & (bit_cnt == 3'd0));
   assign tx_shift_en  = fall_evt & ~frame_start & (bit_cnt != 3'd0);

   // Bit counter and receive shifter; both clear on either frame boundary
   // so an aborted byte leaves nothing behind.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt  <= 3'd0;
         rx_shift <= 8'h00;
      end else if (frame_start || frame_end) begin
         bit_cnt  <= 3'd0;
         rx_shift <= 8'h00;
      end else if (rise_evt) begin
         bit_cnt  <= bit_cnt + 3'd1;
         rx_shift <= rx_byte;
      end
   end

   // Transmit shifter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         tx_shift <= 8'h00;
      end else if (tx_load) begin
         tx_shift <= next_tx_byte;
      end else if (tx_shift_en) begin
         tx_shift <= {tx_shift[6:0], 1'b0};
      end
   end

   // Holding register. A write in the same cycle as a load from an empty
   // register stays queued for the following load.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hold_dat  <= 8'h00;
         hold_full <= 1'b0;
      end else if (tx_load && hold_full) begin
         hold_full <= 1'b0;
      end else if (tx_data_vld && !hold_full) begin
         hold_dat  <= tx_data;
         hold_full <= 1'b1;
      end
   end

   // Receive byte, availability and overrun. An ack coinciding with a new
   // byte counts as having read the old one, so no overrun.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_data    <= 8'h00;
         rx_avail   <= 1'b0;
         rx_overrun <= 1'b0;
      end else begin
         if (byte_done) begin
            rx_data  <= rx_byte;
            rx_avail <= 1'b1;
         end else if (rx_ack) begin
            rx_avail <= 1'b0;
         end

         if (byte_done && rx_avail && !rx_ack) begin
            rx_overrun <= 1'b1;
         end else if (rx_ack) begin
            rx_overrun <= 1'b0;
         end
      end
   end

   assign spi_miso   = (state == ST_ACTIVE) ? tx_shift[7] : 1'b1;
   assign tx_ready   = ~hold_full;
   assign spi_active = ~ss_s;

endmodule

// File: tb/tb_tk1_spi_slave.sv
module tb_tk1_spi_slave;

   logic       clk = 1'b0;
   logic       reset_n = 1'b1;
   logic       spi_ss;
   logic       spi_sck;
   logic       spi_mosi;
   logic       spi_miso;
   logic [7:0] tx_data;
   logic       tx_data_vld;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_avail;
   logic       rx_ack;
   logic       rx_overrun;
   logic       spi_active;

   int n_chk = 0;
   int n_err = 0;
   int H = 4;   // SCK half period in clk cycles

   tk1_spi_slave #(.IDLE_FILL(8'hff)) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .spi_ss     (spi_ss),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso),
      .tx_data    (tx_data),
      .tx_data_vld(tx_data_vld),
      .tx_ready   (tx_ready),
      .rx_data    (rx_data),
      .rx_avail   (rx_avail),
      .rx_ack     (rx_ack),
      .rx_overrun (rx_overrun),
      .spi_active (spi_active)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_tx(input logic [7:0] b);
      tx_data     = b;
      tx_data_vld = 1'b1;
      tick(1);
      tx_data_vld = 1'b0;
   endtask

   task automatic do_ack();
      rx_ack = 1'b1;
      tick(1);
      rx_ack = 1'b0;
   endtask

   task automatic ss_low();
      spi_ss = 1'b0;
      tick(4);
   endtask

   task automatic ss_high();
      tick(H);
      spi_ss = 1'b1;
      tick(4);
   endtask

   // Mode-0 master: nbits bits MSB first, sampling MISO just before each
   // rising edge. Optionally queues qb during the high phase of the last bit.
   task automatic xfer(input logic [7:0] mo, input int nbits, input logic q_en,
                       input logic [7:0] qb, output logic [7:0] mi);
      mi = 8'h00;
      for (int i = 7; i >= 8 - nbits; i--) begin
         spi_mosi = mo[i];
         tick(H);
         mi[i]   = spi_miso;
         spi_sck = 1'b1;
         if (i == 0 && q_en) begin
            push_tx(qb);
            tick(H - 1);
         end else begin
            tick(H);
         end
         spi_sck = 1'b0;
      end
   endtask

   typedef struct {
      logic       ack_b;
      logic       q_en;
      logic [7:0] q;
      logic [7:0] mo;
      logic [7:0] e_miso;
      logic [7:0] e_rx;
      logic       e_av;
      logic       e_ov;
   } vec_t;

   vec_t tbl[5];

   logic [7:0] mi;
   logic [7:0] mi2;

   // reference model state for the random phase
   logic [7:0] m_hold;
   logic       m_hold_v;
   logic [7:0] m_rx;
   logic       m_av;
   logic       m_ov;

   initial begin
      tbl[0] = '{1'b1, 1'b1, 8'hA5, 8'h3C, 8'hA5, 8'h3C, 1'b1, 1'b0};
      tbl[1] = '{1'b1, 1'b0, 8'h00, 8'h01, 8'hFF, 8'h01, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'h7E, 8'h02, 8'h7E, 8'h02, 1'b1, 1'b1};
      tbl[3] = '{1'b1, 1'b0, 8'h00, 8'hC3, 8'hFF, 8'hC3, 1'b1, 1'b0};
      tbl[4] = '{1'b0, 1'b1, 8'h00, 8'hFF, 8'h00, 8'hFF, 1'b1, 1'b1};

      spi_ss      = 1'b1;
      spi_sck     = 1'b0;
      spi_mosi    = 1'b0;
      tx_data     = 8'h00;
      tx_data_vld = 1'b0;
      rx_ack      = 1'b0;

      // ---------------- reset state ----------------
      #2 reset_n = 1'b0;
      #1;
      chk("rst miso", spi_miso, 1'b1);
      chk("rst tx_ready", tx_ready, 1'b1);
      chk("rst rx_data", rx_data, 8'h00);
      chk("rst rx_avail", rx_avail, 1'b0);
      chk("rst rx_overrun", rx_overrun, 1'b0);
      chk("rst spi_active", spi_active, 1'b0);
      tick(3);
      reset_n = 1'b1;
      tick(3);

      // ---------------- table vectors: one byte per frame ----------------
      for (int k = 0; k < 5; k++) begin
         if (tbl[k].ack_b) do_ack();
         if (tbl[k].q_en) begin
            push_tx(tbl[k].q);
            chk($sformatf("tbl%0d tx_ready after write", k), tx_ready, 1'b0);
         end
         ss_low();
         chk($sformatf("tbl%0d tx_ready after ss", k), tx_ready, 1'b1);
         chk($sformatf("tbl%0d spi_active", k), spi_active, 1'b1);
         xfer(tbl[k].mo, 8, 1'b0, 8'h00, mi);
         ss_high();
         chk($sformatf("tbl%0d miso byte", k), mi, tbl[k].e_miso);
         chk($sformatf("tbl%0d rx_data", k), rx_data, tbl[k].e_rx);
         chk($sformatf("tbl%0d rx_avail", k), rx_avail, tbl[k].e_av);
         chk($sformatf("tbl%0d rx_overrun", k), rx_overrun, tbl[k].e_ov);
         chk($sformatf("tbl%0d idle miso", k), spi_miso, 1'b1);
      end

      // ---------------- two-byte frame, response queued mid-frame ----------------
      do_ack();
      ss_low();
      xfer(8'h9F, 8, 1'b1, 8'hEF, mi);
      xfer(8'h00, 8, 1'b0, 8'h00, mi2);
      ss_high();
      chk("seq2 first miso", mi, 8'hFF);
      chk("seq2 second miso", mi2, 8'hEF);
      chk("seq2 rx_data", rx_data, 8'h00);
      chk("seq2 rx_overrun", rx_overrun, 1'b1);
      do_ack();
      chk("ack clears avail", rx_avail, 1'b0);
      chk("ack clears overrun", rx_overrun, 1'b0);

      // ---------------- write while full is ignored ----------------
      push_tx(8'h11);
      chk("full tx_ready", tx_ready, 1'b0);
      push_tx(8'h22);
      chk("full tx_ready again", tx_ready, 1'b0);
      ss_low();
      xfer(8'hAA, 8, 1'b0, 8'h00, mi);
      ss_high();
      chk("full miso keeps first", mi, 8'h11);
      chk("full rx_data", rx_data, 8'hAA);

      // ---------------- aborted partial byte ----------------
      do_ack();
      ss_low();
      xfer(8'hFF, 5, 1'b0, 8'h00, mi);
      ss_high();
      chk("partial rx_avail", rx_avail, 1'b0);
      chk("partial rx_data", rx_data, 8'hAA);
      ss_low();
      xfer(8'h55, 8, 1'b0, 8'h00, mi);
      ss_high();
      chk("after partial rx_data", rx_data, 8'h55);
      chk("after partial rx_avail", rx_avail, 1'b1);
      chk("after partial overrun", rx_overrun, 1'b0);
      chk("after partial miso", mi, 8'hFF);

      // ---------------- reset mid-byte ----------------
      ss_low();
      push_tx(8'h5A);
      xfer(8'hC0, 3, 1'b0, 8'h00, mi);
      tick(H);
      spi_mosi = 1'b1;
      spi_sck  = 1'b1;
      tick(2);
      reset_n = 1'b0;
      #1;
      chk("midrst miso", spi_miso, 1'b1);
      chk("midrst tx_ready", tx_ready, 1'b1);
      chk("midrst rx_data", rx_data, 8'h00);
      chk("midrst rx_avail", rx_avail, 1'b0);
      chk("midrst rx_overrun", rx_overrun, 1'b0);
      chk("midrst spi_active", spi_active, 1'b0);
      spi_sck  = 1'b0;
      spi_ss   = 1'b1;
      spi_mosi = 1'b0;
      tick(3);
      reset_n = 1'b1;
      tick(5);
      chk("post rst no spurious byte", rx_avail, 1'b0);
      push_tx(8'hA5);
      chk("post rst tx_ready full", tx_ready, 1'b0);
      ss_low();
      chk("post rst tx_ready after ss", tx_ready, 1'b1);
      xfer(8'h3C, 8, 1'b0, 8'h00, mi);
      ss_high();
      chk("post rst miso", mi, 8'hA5);
      chk("post rst rx_data", rx_data, 8'h3C);
      chk("post rst rx_avail", rx_avail, 1'b1);
      chk("post rst overrun", rx_overrun, 1'b0);

      // ---------------- randomized frames vs reference model ----------------
      m_hold   = 8'h00;
      m_hold_v = 1'b0;
      m_rx     = 8'h3C;
      m_av     = 1'b1;
      m_ov     = 1'b0;
      for (int f = 0; f < 25; f++) begin
         int         nfull;
         int         npart;
         logic [7:0] exp_b;
         logic [7:0] mo;
         logic [7:0] qb;
         logic       qe;
         H = $urandom_range(3, 5);
         if ($urandom_range(0, 2) == 0) begin
            do_ack();
            m_av = 1'b0;
            m_ov = 1'b0;
         end
         if ($urandom_range(0, 1) == 1) begin
            qb = 8'($urandom);
            push_tx(qb);
            if (!m_hold_v) begin
               m_hold   = qb;
               m_hold_v = 1'b1;
            end
         end
         nfull = $urandom_range(0, 2);
         npart = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 7) : 0;
         if (nfull == 0 && npart == 0) nfull = 1;

         ss_low();
         exp_b    = m_hold_v ? m_hold : 8'hFF;
         m_hold_v = 1'b0;
         for (int b = 0; b < nfull; b++) begin
            mo = 8'($urandom);
            qe = 1'($urandom_range(0, 1));
            qb = 8'($urandom);
            xfer(mo, 8, qe, qb, mi);
            chk($sformatf("rnd%0d byte%0d miso", f, b), mi, exp_b);
            if (qe && !m_hold_v) begin
               m_hold   = qb;
               m_hold_v = 1'b1;
            end
            exp_b    = m_hold_v ? m_hold : 8'hFF;
            m_hold_v = 1'b0;
            if (m_av) m_ov = 1'b1;
            m_rx = mo;
            m_av = 1'b1;
         end
         if (npart != 0) begin
            mo = 8'($urandom);
            xfer(mo, npart, 1'b0, 8'h00, mi);
            chk($sformatf("rnd%0d partial miso", f), mi >> (8 - npart), exp_b >> (8 - npart));
         end
         ss_high();
         chk($sformatf("rnd%0d rx_data", f), rx_data, m_rx);
         chk($sformatf("rnd%0d rx_avail", f), rx_avail, m_av);
         chk($sformatf("rnd%0d rx_overrun", f), rx_overrun, m_ov);
         chk($sformatf("rnd%0d tx_ready", f), tx_ready, !m_hold_v);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
